axil_cmd_master: RTL and testbench
==================================

AXIL_CMD_MASTER -- requirements
Module: axil_cmd_master

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- ADDR_SIZE, 32, AXI-Lite address width.
- DATA_WIDTH, 32, AXI-Lite data width; legal values are 32 and 64.
- num_strobe, DATA_WIDTH/8, strobe width.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- aclk, in, 1, sole clock; all logic is synchronous to its rising edge.
- areset, in, 1, reset; synchronous, active-high.
- cmd_valid, in, 1, command request.
- cmd_ready, out, 1, command accepted this cycle.
- cmd_write, in, 1, 1 = write, 0 = read.
- cmd_addr, in, ADDR_SIZE, target address.
- cmd_wdata, in, DATA_WIDTH, write data.
- cmd_wstrb, in, num_strobe, write strobes.
- awaddr/awvalid/awready, out/out/in, ADDR_SIZE/1/1, AXI-Lite write address channel.
- wdata/wstrb/wvalid/wready, out/out/out/in, DATA_WIDTH/num_strobe/1/1, AXI-Lite write data channel.
- bresp/bvalid/bready, in/in/out, 2/1/1, AXI-Lite write response channel.
- araddr/arvalid/arready, out/out/in, ADDR_SIZE/1/1, AXI-Lite read address channel.
- rdata/rresp/rvalid/rready, in/in/in/out, DATA_WIDTH/2/1/1, AXI-Lite read data channel.
- rsp_valid, out, 1, transaction result available.
- rsp_ready, in, 1, result consumed.
- rsp_write, out, 1, result belongs to a write.
- rsp_rdata, out, DATA_WIDTH, read data (0 for writes).
- rsp_resp, out, 2, BRESP or RRESP.
- err_sticky, out, 1, set on any non-OKAY response.
- err_clr, in, 1, clears err_sticky.
- txn_count, out, 16, completed transactions; wraps.

Function
REQ-003 The state machine SHALL have states IDLE, WR, WR_B, RD_A, RD_R and RSP.
REQ-004 cmd_ready SHALL be 1 only in IDLE, and a command SHALL be accepted when cmd_valid and cmd_ready are both 1.
REQ-005 On acceptance, cmd_addr, cmd_wdata and cmd_wstrb SHALL be registered, and the next state SHALL be WR (write) or RD_A (read).
REQ-006 In WR, awvalid and wvalid SHALL both be 1 from the first cycle after acceptance.
REQ-007 awvalid and wvalid SHALL each deassert the cycle after their own handshake, independently; a same-cycle handshake on both channels is legal.
REQ-008 WR SHALL exit to WR_B only when both the AW and W handshakes have completed.
REQ-009 In WR_B, bready SHALL be 1; on bvalid the block SHALL capture bresp and move to RSP.
REQ-010 In RD_A, arvalid SHALL be 1 until the arready handshake, then the block SHALL move to RD_R.
REQ-011 In RD_R, rready SHALL be 1; on rvalid the block SHALL capture rdata and rresp and move to RSP.
REQ-012 All AXI valid outputs SHALL be registered, SHALL NOT depend combinationally on the matching ready, and SHALL hold address/data stable until their handshake.
REQ-013 In RSP, rsp_valid SHALL be 1 with stable rsp_* fields; on rsp_ready the block SHALL return to IDLE. rsp_ready may already be high on entry, giving a one-cycle RSP.
REQ-014 Minimum latency, with zero-wait slave and rsp_ready tied high: cmd accept in cycle 0, AW/W handshake in cycle 1, B in cycle 2, rsp_valid in cycle 3, cmd_ready in cycle 4. Reads follow the same timing.
REQ-015 txn_count SHALL increment by 1 on each RSP handshake and wrap from 0xFFFF to 0.
REQ-016 err_sticky SHALL set on capture of a response whose value is not 2'b00.
REQ-017 When err_clr coincides with a new error capture, the set SHALL win.
REQ-018 Only one transaction SHALL be outstanding at any time, and the block SHALL never abandon a transaction. There is no timeout.
REQ-019 Non-command inputs SHALL be ignored while cmd_ready is 0.

Reset
REQ-020 While areset is 1, the state SHALL be IDLE.
REQ-021 While areset is 1, all valid/ready outputs except cmd_ready SHALL be 0, and cmd_ready SHALL be 0 during reset and 1 in the first cycle after it.
REQ-022 While areset is 1, the registered address, data and response fields SHALL be 0, txn_count SHALL be 0 and err_sticky SHALL be 0.
REQ-023 Reset asserted mid-transaction SHALL discard that transaction with no response; the slave is reset on the same areset.

Structure
REQ-024 A shared package SHALL hold the state enum and the AXI response constants OKAY=0, EXOKAY=1, SLVERR=2 and DECERR=3.
REQ-025 One sub-module, axil_valid_hold, SHALL implement the per-channel "assert valid, hold until handshake" register and SHALL be instantiated four times (AW, W, AR and cmd-to-response).

Verification
REQ-026 Write 0xDEADBEEF to 0x10 with wstrb 0xF, zero-wait slave -> bus shows awaddr=0x10, wdata=0xDEADBEEF, wstrb=0xF; rsp_valid in cycle 3 with rsp_resp=0; txn_count=1.
REQ-027 Read 0x14 with slave rdata=0x12345678, arready delayed 3 cycles -> arvalid held 4 cycles with araddr stable; rsp_rdata=0x12345678; rsp_write=0.
REQ-028 Write where wready arrives 5 cycles before awready -> wvalid drops after its handshake while awvalid stays high; exactly one B is accepted.
REQ-029 Read returning rresp=2 with err_clr pulsed in the same capture cycle -> err_sticky=1; a later err_clr alone clears it to 0.
REQ-030 Hold rsp_ready=0 for 10 cycles with cmd_valid=1 -> rsp fields stable and cmd_ready=0 throughout; the next command is accepted the cycle after rsp_ready.
REQ-031 Assert areset in RD_R -> next cycle all valids are 0, txn_count=0, no rsp_valid; the first post-reset command completes normally.

Source files
------------

// File: rtl/axil_cmd_master_pkg.sv
// Shared definitions for the AXI-Lite command master: FSM state encodings,
// AXI response codes and a small response classification helper.
package axil_cmd_master_pkg;

    // FSM state encodings
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_WR   = 3'd1;
    localparam logic [2:0] ST_WR_B = 3'd2;
    localparam logic [2:0] ST_RD_A = 3'd3;
    localparam logic [2:0] ST_RD_R = 3'd4;
    localparam logic [2:0] ST_RSP  = 3'd5;

    // AXI response codes
    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_EXOKAY = 2'd1;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] RESP_DECERR = 2'd3;

    // Any response other than OKAY counts as an error for the sticky flag
    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp != RESP_OKAY);
    endfunction

endpackage

// File: rtl/axil_cmd_master_valid.sv
// Per-channel "assert valid, hold payload until handshake" register.
// valid is purely registered: it never depends combinationally on ready.
module axil_valid_hold #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         areset,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] data
);

    logic         valid_r;
    logic [W-1:0] data_r;

    // Capture payload on load, drop valid the cycle after the handshake
    always_ff @(posedge clk) begin
        if (areset) begin
            valid_r <= 1'b0;
            data_r  <= '0;
        end else if (load) begin
            valid_r <= 1'b1;
            data_r  <= load_data;
        end else if (valid_r && ready) begin
            valid_r <= 1'b0;
        end
    end

    assign valid = valid_r;
    assign data  = data_r;

endmodule

// File: rtl/axil_cmd_master.sv
// Single-outstanding AXI-Lite master: takes one read or write command,
// runs it on the bus, and presents the result on a response handshake.
module axil_cmd_master
    import axil_cmd_master_pkg::*;
#(
    parameter int ADDR_SIZE  = 32,
    parameter int DATA_WIDTH = 32,
    parameter int num_strobe = DATA_WIDTH / 8
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_SIZE-1:0]  cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [num_strobe-1:0] cmd_wstrb,
    output logic [ADDR_SIZE-1:0]  awaddr,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic [num_strobe-1:0] wstrb,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready,
    output logic [ADDR_SIZE-1:0]  araddr,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
    output logic                  rready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic                  err_sticky,
    input  logic                  err_clr,
    output logic [15:0]           txn_count
);

    localparam int WB_W  = DATA_WIDTH + num_strobe;
    localparam int RSP_W = 1 + DATA_WIDTH + 2;

    logic [2:0]       state_r;
    logic [2:0]       next_state_s;
    logic             cmd_ready_r;
    logic             bready_r;
    logic             rready_r;
    logic             err_sticky_r;
    logic [15:0]      txn_count_r;

    logic             accept_s;
    logic             wr_done_s;
    logic             b_cap_s;
    logic             r_cap_s;
    logic             cap_s;
    logic [1:0]       cap_resp_s;
    logic             rsp_hs_s;
    logic [WB_W-1:0]  w_hold_s;
    logic [RSP_W-1:0] rsp_load_s;
    logic [RSP_W-1:0] rsp_hold_s;

    assign accept_s  = cmd_valid && cmd_ready_r;
    // Each write channel is finished once its valid has dropped or is handshaking now
    assign wr_done_s = (!awvalid || awready) && (!wvalid || wready);
    assign b_cap_s   = bready_r && bvalid;
    assign r_cap_s   = rready_r && rvalid;
    assign cap_s     = b_cap_s || r_cap_s;
    assign rsp_hs_s  = rsp_valid && rsp_ready;

    // Select the response being captured; reads carry data, writes carry zero
    always_comb begin
        cap_resp_s = rresp;
        rsp_load_s = {1'b0, rdata, rresp};
        if (b_cap_s) begin
            cap_resp_s = bresp;
            rsp_load_s = {1'b1, {DATA_WIDTH{1'b0}}, bresp};
        end else begin
            cap_resp_s = rresp;
            rsp_load_s = {1'b0, rdata, rresp};
        end
    end

    // Next-state logic for the single-transaction sequencer
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) next_state_s = cmd_write ? ST_WR : ST_RD_A;
                else          next_state_s = ST_IDLE;
            end
            ST_WR: begin
                if (wr_done_s) next_state_s = ST_WR_B;
                else           next_state_s = ST_WR;
            end
            ST_WR_B: begin
                if (b_cap_s) next_state_s = ST_RSP;
                else         next_state_s = ST_WR_B;
            end
            ST_RD_A: begin
                if (arvalid && arready) next_state_s = ST_RD_R;
                else                    next_state_s = ST_RD_A;
            end
            ST_RD_R: begin
                if (r_cap_s) next_state_s = ST_RSP;
                else         next_state_s = ST_RD_R;
            end
            ST_RSP: begin
                if (rsp_hs_s) next_state_s = ST_IDLE;
                else          next_state_s = ST_RSP;
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // State register and registered ready outputs decoded from the next state
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_r     <= ST_IDLE;
            cmd_ready_r <= 1'b0;
            bready_r    <= 1'b0;
            rready_r    <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            cmd_ready_r <= (next_state_s == ST_IDLE);
            bready_r    <= (next_state_s == ST_WR_B);
            rready_r    <= (next_state_s == ST_RD_R);
        end
    end

    // Sticky error flag (a new error beats a coincident clear) and completion counter
    always_ff @(posedge aclk) begin
        if (areset) begin
            err_sticky_r <= 1'b0;
            txn_count_r  <= 16'd0;
        end else begin
            if (cap_s && resp_is_err(cap_resp_s)) err_sticky_r <= 1'b1;
            else if (err_clr)                     err_sticky_r <= 1'b0;
            if (rsp_hs_s) txn_count_r <= txn_count_r + 16'd1;
        end
    end

    axil_valid_hold #(.W(ADDR_SIZE)) u_aw (
        .clk(aclk), .areset(areset), .load(accept_s && cmd_write), .load_data(cmd_addr),
        .ready(awready), .valid(awvalid), .data(awaddr)
    );

    axil_valid_hold #(.W(WB_W)) u_w (
        .clk(aclk), .areset(areset), .load(accept_s && cmd_write), .load_data({cmd_wdata, cmd_wstrb}),
        .ready(wready), .valid(wvalid), .data(w_hold_s)
    );

    axil_valid_hold #(.W(ADDR_SIZE)) u_ar (
        .clk(aclk), .areset(areset), .load(accept_s && !cmd_write), .load_data(cmd_addr),
        .ready(arready), .valid(arvalid), .data(araddr)
    );

    axil_valid_hold #(.W(RSP_W)) u_rsp (
        .clk(aclk), .areset(areset), .load(cap_s), .load_data(rsp_load_s),
        .ready(rsp_ready), .valid(rsp_valid), .data(rsp_hold_s)
    );

    assign wdata      = w_hold_s[WB_W-1:num_strobe];
    assign wstrb      = w_hold_s[num_strobe-1:0];
    assign rsp_write  = rsp_hold_s[RSP_W-1];
    assign rsp_rdata  = rsp_hold_s[RSP_W-2:2];
    assign rsp_resp   = rsp_hold_s[1:0];
    assign cmd_ready  = cmd_ready_r;
    assign bready     = bready_r;
    assign rready     = rready_r;
    assign err_sticky = err_sticky_r;
    assign txn_count  = txn_count_r;

endmodule

// File: tb/tb_axil_cmd_master.sv
// Directed bench for axil_cmd_master: the bench plays the AXI-Lite slave and
// the response consumer; expected responses go through a scoreboard queue.
module tb_axil_cmd_master;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;

    logic          aclk = 1'b0;
    logic          areset;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [SW-1:0] cmd_wstrb;
    logic [AW-1:0] awaddr;
    logic          awvalid, awready;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic          wvalid, wready;
    logic [1:0]    bresp;
    logic          bvalid, bready;
    logic [AW-1:0] araddr;
    logic          arvalid, arready;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rvalid, rready;
    logic          rsp_valid, rsp_ready, rsp_write;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic          err_sticky, err_clr;
    logic [15:0]   txn_count;

    typedef struct packed {
        logic          wr;
        logic [DW-1:0] rdata;
        logic [1:0]    resp;
    } rsp_t;

    rsp_t        sb_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic [15:0] exp_txn = 16'd0;

    always #5 aclk = ~aclk;

    // Free-running cycle index used for latency measurements
    always @(posedge aclk) cyc <= cyc + 1;

    axil_cmd_master #(.ADDR_SIZE(AW), .DATA_WIDTH(DW), .num_strobe(SW)) dut (
        .aclk(aclk), .areset(areset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .err_sticky(err_sticky), .err_clr(err_clr), .txn_count(txn_count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        n_vec++;
        n_err++;
        $error("FAIL %s: observed timeout expected handshake", tag);
    endtask

    // Present a command at the current negedge; returns the cycle index of acceptance
    task automatic send_cmd(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input logic [SW-1:0] strb, output int acc);
        int k = 0;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
        while (!cmd_ready && k < 50) begin @(negedge aclk); k++; end
        if (!cmd_ready) timeout("cmd_accept");
        acc = cyc;
        @(negedge aclk);
        cmd_valid = 1'b0;
    endtask

    // Consume one response; hold>0 stalls rsp_ready (caller already lowered it)
    // while a follow-up read command is kept pending.
    task automatic get_rsp(input int acc, input bit chk_lat, input int hold, output int hs_cyc);
        rsp_t exp;
        int k = 0;
        exp = '0;
        while (!rsp_valid && k < 50) begin @(negedge aclk); k++; end
        if (!rsp_valid) timeout("rsp_valid");
        if (chk_lat) check("rsp_latency", 64'(cyc - acc), 64'd3);
        if (sb_q.size() == 0) timeout("scoreboard_empty");
        else exp = sb_q.pop_front();
        for (int i = 0; i < hold; i++) begin
            cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h44;
            check("hold_rsp_valid", rsp_valid, 1'b1);
            check("hold_rsp_rdata", rsp_rdata, exp.rdata);
            check("hold_rsp_write", rsp_write, exp.wr);
            check("hold_cmd_ready", cmd_ready, 1'b0);
            @(negedge aclk);
        end
        rsp_ready = 1'b1;
        check("rsp_write", rsp_write, exp.wr);
        check("rsp_rdata", rsp_rdata, exp.rdata);
        check("rsp_resp", rsp_resp, exp.resp);
        hs_cyc = cyc;
        @(negedge aclk);
        exp_txn = exp_txn + 16'd1;
        check("txn_count", txn_count, exp_txn);
        check("rsp_valid_drop", rsp_valid, 1'b0);
        check("cmd_ready_back", cmd_ready, 1'b1);
    endtask

    task automatic write_txn(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [SW-1:0] strb,
                             input int aw_dly, input int w_dly, input logic [1:0] resp,
                             input bit chk_lat, input int hold, output int hs_cyc);
        int acc;
        int k = 0;
        bit aw_done = 1'b0;
        bit w_done = 1'b0;
        sb_q.push_back(rsp_t'{1'b1, 32'h0, resp});
        send_cmd(1'b1, addr, data, strb, acc);
        while (!(aw_done && w_done) && k < 50) begin
            if (aw_done) check("awvalid_drop", awvalid, 1'b0);
            else begin
                check("awvalid", awvalid, 1'b1);
                check("awaddr", awaddr, addr);
            end
            if (w_done) check("wvalid_drop", wvalid, 1'b0);
            else begin
                check("wvalid", wvalid, 1'b1);
                check("wdata", wdata, data);
                check("wstrb", wstrb, strb);
            end
            awready = !aw_done && (k >= aw_dly);
            wready  = !w_done && (k >= w_dly);
            @(negedge aclk);
            if (awready) aw_done = 1'b1;
            if (wready)  w_done  = 1'b1;
            awready = 1'b0; wready = 1'b0;
            k++;
        end
        if (!(aw_done && w_done)) timeout("aw_w_handshake");
        check("awvalid_after", awvalid, 1'b0);
        check("wvalid_after", wvalid, 1'b0);
        k = 0;
        while (!bready && k < 50) begin @(negedge aclk); k++; end
        if (!bready) timeout("bready");
        bvalid = 1'b1; bresp = resp;
        @(negedge aclk);
        // bvalid stays high: a second B must not be accepted
        check("single_b", bready, 1'b0);
        get_rsp(acc, chk_lat, hold, hs_cyc);
        bvalid = 1'b0; bresp = 2'd0;
    endtask

    task automatic read_txn(input logic [AW-1:0] addr, input int ar_dly, input logic [DW-1:0] rd,
                            input logic [1:0] resp, input bit clr_at_cap, input bit chk_lat,
                            output int acc);
        int k = 0;
        int n_ar = 0;
        int hs;
        sb_q.push_back(rsp_t'{1'b0, rd, resp});
        send_cmd(1'b0, addr, 32'h0, 4'h0, acc);
        while (k < 50) begin
            check("arvalid", arvalid, 1'b1);
            check("araddr", araddr, addr);
            arready = (k >= ar_dly);
            @(negedge aclk);
            n_ar++;
            if (arready) break;
            k++;
        end
        arready = 1'b0;
        check("ar_cycles", 64'(n_ar), 64'(ar_dly + 1));
        check("arvalid_after", arvalid, 1'b0);
        k = 0;
        while (!rready && k < 50) begin @(negedge aclk); k++; end
        if (!rready) timeout("rready");
        rvalid = 1'b1; rdata = rd; rresp = resp; err_clr = clr_at_cap;
        @(negedge aclk);
        rvalid = 1'b0; rdata = 32'h0; rresp = 2'd0; err_clr = 1'b0;
        check("rready_drop", rready, 1'b0);
        get_rsp(acc, chk_lat, 0, hs);
    endtask

    initial begin
        int hs;
        int acc;
        areset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0;
        cmd_wdata = 32'h0; cmd_wstrb = 4'h0; awready = 1'b0; wready = 1'b0;
        bresp = 2'd0; bvalid = 1'b0; arready = 1'b0; rdata = 32'h0; rresp = 2'd0;
        rvalid = 1'b0; rsp_ready = 1'b1; err_clr = 1'b0;

        // Reset state
        repeat (3) @(negedge aclk);
        check("rst_cmd_ready", cmd_ready, 1'b0);
        check("rst_valids", {awvalid, wvalid, arvalid, rsp_valid}, 4'h0);
        check("rst_readies", {bready, rready}, 2'b00);
        check("rst_txn", txn_count, 16'd0);
        check("rst_err", err_sticky, 1'b0);
        check("rst_fields", {awaddr, wdata, araddr, rsp_rdata}, 128'h0);
        areset = 1'b0;
        @(negedge aclk);
        check("post_rst_cmd_ready", cmd_ready, 1'b1);

        // Zero-wait write with latency check
        write_txn(32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 2'd0, 1'b1, 0, hs);
        // Read with arready delayed 3 cycles
        read_txn(32'h14, 3, 32'h12345678, 2'd0, 1'b0, 1'b0, acc);
        // W handshake 5 cycles ahead of AW
        write_txn(32'h20, 32'hA5A50F0F, 4'h3, 5, 0, 2'd0, 1'b0, 0, hs);
        check("err_before", err_sticky, 1'b0);

        // SLVERR read with a coincident clear: set wins
        read_txn(32'h30, 0, 32'hCAFE0001, 2'd2, 1'b1, 1'b1, acc);
        check("err_set_wins", err_sticky, 1'b1);
        err_clr = 1'b1;
        @(negedge aclk);
        err_clr = 1'b0;
        check("err_cleared", err_sticky, 1'b0);

        // DECERR on a write also sets the flag
        write_txn(32'h24, 32'h00000001, 4'h1, 0, 0, 2'd3, 1'b1, 0, hs);
        check("err_write", err_sticky, 1'b1);
        err_clr = 1'b1;
        @(negedge aclk);
        err_clr = 1'b0;

        // Response back-pressure for 10 cycles with a command waiting
        rsp_ready = 1'b0;
        write_txn(32'h40, 32'h0BADF00D, 4'hC, 0, 0, 2'd0, 1'b0, 10, hs);
        read_txn(32'h44, 0, 32'h87654321, 2'd0, 1'b0, 1'b1, acc);
        check("accept_after_rsp", 64'(acc), 64'(hs + 1));

        // Reset in RD_R discards the read
        send_cmd(1'b0, 32'h50, 32'h0, 4'h0, acc);
        arready = 1'b1;
        @(negedge aclk);
        arready = 1'b0;
        check("in_rd_r", rready, 1'b1);
        areset = 1'b1;
        @(negedge aclk);
        check("mid_rst_valids", {awvalid, wvalid, arvalid, rsp_valid}, 4'h0);
        check("mid_rst_readies", {cmd_ready, bready, rready}, 3'b000);
        check("mid_rst_txn", txn_count, 16'd0);
        areset = 1'b0;
        exp_txn = 16'd0;
        @(negedge aclk);
        check("mid_rst_cmd_ready", cmd_ready, 1'b1);
        write_txn(32'h60, 32'h13579BDF, 4'hF, 0, 0, 2'd0, 1'b1, 0, hs);
        // EXOKAY is also a non-OKAY response
        read_txn(32'h64, 0, 32'h2468ACE0, 2'd1, 1'b0, 1'b1, acc);
        check("err_exokay", err_sticky, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
